alarm_bank: RTL
===============

Name: alarm_bank

Overview:
Multi-slot alarm and chime controller, the parametrised successor to the DigitalClock single-alarm/hourly-chime logic. It holds NUM_ALARMS independently programmable alarm slots and compares them against the running time once per second. It adds snooze, ring timeout, priority arbitration and an hourly chime, and drives one beep output. It sits between the timekeeping counters, the debounced key pulses and the buzzer pin.

Parameters:
NUM_ALARMS, 4, number of alarm slots (>=2); IDX_W = $clog2(NUM_ALARMS) is a localparam
DEFAULT_HOUR, 6, reset hour of every slot (minute resets to 0)
SNOOZE_SEC, 300, seconds spent in snooze before re-ringing
RING_TIMEOUT_SEC, 60, seconds of unacknowledged ringing before auto-off
CHIME_SEC, 2, length of the hourly chime beep in seconds

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
tick_1hz  in  1  one-cycle pulse per second; cur_* are valid on this cycle
cur_hour  in  5  current hour, 0..23
cur_min  in  6  current minute, 0..59
cur_sec  in  6  current second, 0..59
wr_en  in  1  slot write strobe
wr_idx  in  IDX_W  slot to write
wr_hour  in  5  alarm hour
wr_min  in  6  alarm minute
wr_enable  in  1  slot armed flag
rd_idx  in  IDX_W  slot to read back for display
rd_hour  out  5  registered readback of the slot hour
rd_min  out  6  registered readback of the slot minute
rd_enable  out  1  registered readback of the slot armed flag
key_off  in  1  debounced one-cycle pulse that cancels ringing or snooze
key_snooze  in  1  debounced one-cycle pulse that starts snooze
chime_en  in  1  enables the hourly chime
beep  out  1  buzzer drive
ringing  out  1  high while in S_RING
snoozing  out  1  high while in S_SNOOZE
active_idx  out  IDX_W  slot that owns the current ring or snooze

Behaviour:
- Reset (rst=0, asynchronous): every slot is hour=DEFAULT_HOUR, min=0, disabled. State goes to S_IDLE. All outputs and counters are 0; rd_* is 0 until the first clock after reset release.
- Writes: on the clock edge where wr_en=1, the slot is updated. The write is ignored entirely if wr_idx>=NUM_ALARMS, wr_hour>23 or wr_min>59. Writing wr_enable=0 to active_idx while in S_RING or S_SNOOZE forces S_IDLE on the same edge.
- Readback: rd_* reflects rd_idx with 1-cycle latency and shows a write one cycle after it lands. rd_idx>=NUM_ALARMS returns 0s.
- Match: evaluated only on tick_1hz=1 cycles. A slot matches when it is enabled, cur_sec==0, cur_hour==hour and cur_min==min. When several slots match, the lowest index wins.
- FSM states: S_IDLE, S_RING, S_SNOOZE, S_CHIME. Transitions are registered; outputs follow one cycle after the deciding edge.
- S_IDLE: a match goes to S_RING with active_idx=winner and sec_cnt=0. Otherwise, if chime_en=1, cur_min==0 and cur_sec==0 on the tick, go to S_CHIME.
- S_RING:
  - key_off goes to S_IDLE.
  - key_snooze goes to S_SNOOZE and loads sec_cnt=SNOOZE_SEC.
  - Each tick increments sec_cnt; when it reaches RING_TIMEOUT_SEC, go to S_IDLE.
  - New matches are ignored.
  - beep = phase, which is cleared on entry and toggles every tick (1 s on, 1 s off, starting on).
- S_SNOOZE:
  - beep=0.
  - Each tick decrements sec_cnt; on reaching 0, go to S_RING with the same idx, sec_cnt=0 and phase=1.
  - key_off goes to S_IDLE.
  - A match from any slot preempts: go to S_RING with the new idx, and the snooze is discarded.
- S_CHIME: beep=1 for CHIME_SEC ticks, then S_IDLE. A match during a chime preempts to S_RING. A chime is never started from S_RING or S_SNOOZE.
- Simultaneous events:
  - Alarm match beats chime on the same tick.
  - key_off beats key_snooze and tick handling on the same cycle.
  - key_snooze arriving on the timeout tick takes priority over the timeout.
- key_* outside the states that use them are ignored.
- Slots are never modified by the FSM; a ringing slot stays armed and fires again the next day.

Test Plan:
- Reset: rst low for 3 cycles → all rd_* for idx 0..3 read 6/0/0; beep=0, ringing=0.
- Basic ring and off: write slot1=07:30 enabled; drive tick at 07:30:00 → ringing=1 and active_idx=1 next cycle. beep is 1,0,1 across ticks. key_off → ringing=0 and beep=0 next cycle.
- Priority and invalid write: slots 2 and 3 both at 08:00 enabled → active_idx=2. Write wr_hour=24 to slot0 → rd_hour stays unchanged.
- Snooze: ring slot0, key_snooze → snoozing=1 and beep=0. After SNOOZE_SEC (override to 3) ticks → ringing=1 with active_idx=0. After RING_TIMEOUT_SEC (override to 5) ticks with no key → S_IDLE.
- Chime vs alarm: chime_en=1 at 09:00:00 with no match → beep=1 for 2 ticks, then 0. Slot0 at 10:00 enabled at 10:00:00 → ringing=1, no chime.
- Preempt and disarm: slot0 snoozing, slot1 matches → ringing with active_idx=1. Write wr_idx=1, wr_enable=0 while ringing → S_IDLE next edge. Assert rst mid-ring → beep=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alarm_bank.sv
// Multi-slot alarm/chime controller: matches armed slots on each 1 Hz tick, arbitrates, drives beep.
// State and outputs register one cycle after the deciding edge; no backpressure, all inputs are strobes.
module alarm_bank #(
    parameter int  NUM_ALARMS       = 4,
    parameter int  DEFAULT_HOUR     = 6,
    parameter int  SNOOZE_SEC       = 300,
    parameter int  RING_TIMEOUT_SEC = 60,
    parameter int  CHIME_SEC        = 2,
    localparam int IDX_W            = $clog2(NUM_ALARMS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic [4:0]       cur_hour,
    input  logic [5:0]       cur_min,
    input  logic [5:0]       cur_sec,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [4:0]       wr_hour,
    input  logic [5:0]       wr_min,
    input  logic             wr_enable,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [4:0]       rd_hour,
    output logic [5:0]       rd_min,
    output logic             rd_enable,
    input  logic             key_off,
    input  logic             key_snooze,
    input  logic             chime_en,
    output logic             beep,
    output logic             ringing,
    output logic             snoozing,
    output logic [IDX_W-1:0] active_idx
);

    localparam int CNT_MAX = (SNOOZE_SEC > RING_TIMEOUT_SEC)
                           ? ((SNOOZE_SEC > CHIME_SEC) ? SNOOZE_SEC : CHIME_SEC)
                           : ((RING_TIMEOUT_SEC > CHIME_SEC) ? RING_TIMEOUT_SEC : CHIME_SEC);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE, S_CHIME} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        sec_cnt;
    logic [4:0]              slot_hour [NUM_ALARMS];
    logic [5:0]              slot_min  [NUM_ALARMS];
    logic [NUM_ALARMS-1:0]   slot_en;

    logic                    wr_ok;
    logic                    rd_ok;
    logic                    hit;
    logic [IDX_W-1:0]        hit_idx;
    logic                    chime_hit;
    logic                    disarm;

    assign wr_ok = wr_en && (32'(wr_idx) < 32'(NUM_ALARMS))
                && (wr_hour <= 5'd23) && (wr_min <= 6'd59);
    assign rd_ok = 32'(rd_idx) < 32'(NUM_ALARMS);

    // Downward scan so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (slot_en[i] && slot_hour[i] == cur_hour && slot_min[i] == cur_min) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
        hit = hit && tick_1hz && (cur_sec == 6'd0);
    end

    assign chime_hit = tick_1hz && chime_en && (cur_min == 6'd0) && (cur_sec == 6'd0);
    assign disarm    = wr_ok && !wr_enable && (wr_idx == active_idx)
                    && (state == S_RING || state == S_SNOOZE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                slot_hour[i] <= 5'(DEFAULT_HOUR);
                slot_min[i]  <= 6'd0;
            end
            slot_en <= '0;
        end else if (wr_ok) begin
            slot_hour[wr_idx] <= wr_hour;
            slot_min[wr_idx]  <= wr_min;
            slot_en[wr_idx]   <= wr_enable;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_hour   <= 5'd0;
            rd_min    <= 6'd0;
            rd_enable <= 1'b0;
        end else if (rd_ok) begin
            rd_hour   <= slot_hour[rd_idx];
            rd_min    <= slot_min[rd_idx];
            rd_enable <= slot_en[rd_idx];
        end else begin
            rd_hour   <= 5'd0;
            rd_min    <= 6'd0;
            rd_enable <= 1'b0;
        end
    end

    // beep doubles as the ring phase: every entry into S_RING starts on the audible half.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            sec_cnt    <= '0;
            active_idx <= '0;
            beep       <= 1'b0;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
        end else if (disarm) begin
            state    <= S_IDLE;
            beep     <= 1'b0;
            ringing  <= 1'b0;
            snoozing <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hit) begin
                        state      <= S_RING;
                        active_idx <= hit_idx;
                        sec_cnt    <= '0;
                        beep       <= 1'b1;
                        ringing    <= 1'b1;
                    end else if (chime_hit) begin
                        state   <= S_CHIME;
                        sec_cnt <= '0;
                        beep    <= 1'b1;
                    end
                end
                S_RING: begin
                    if (key_off) begin
                        state   <= S_IDLE;
                        beep    <= 1'b0;
                        ringing <= 1'b0;
                    end else if (key_snooze) begin
                        state    <= S_SNOOZE;
                        sec_cnt  <= CNT_W'(SNOOZE_SEC);
                        beep     <= 1'b0;
                        ringing  <= 1'b0;
                        snoozing <= 1'b1;
                    end else if (tick_1hz) begin
                        if (sec_cnt + CNT_W'(1) >= CNT_W'(RING_TIMEOUT_SEC)) begin
                            state   <= S_IDLE;
                            beep    <= 1'b0;
                            ringing <= 1'b0;
                        end else begin
                            sec_cnt <= sec_cnt + CNT_W'(1);
                            beep    <= ~beep;
                        end
                    end
                end
                S_SNOOZE: begin
                    if (key_off) begin
                        state    <= S_IDLE;
                        snoozing <= 1'b0;
                    end else if (hit || (tick_1hz && sec_cnt <= CNT_W'(1))) begin
                        state      <= S_RING;
                        active_idx <= hit ? hit_idx : active_idx;
                        sec_cnt    <= '0;
                        beep       <= 1'b1;
                        ringing    <= 1'b1;
                        snoozing   <= 1'b0;
                    end else if (tick_1hz) begin
                        sec_cnt <= sec_cnt - CNT_W'(1);
                    end
                end
                S_CHIME: begin
                    if (hit) begin
                        state      <= S_RING;
                        active_idx <= hit_idx;
                        sec_cnt    <= '0;
                        beep       <= 1'b1;
                        ringing    <= 1'b1;
                    end else if (tick_1hz) begin
                        if (sec_cnt + CNT_W'(1) >= CNT_W'(CHIME_SEC)) begin
                            state <= S_IDLE;
                            beep  <= 1'b0;
                        end else begin
                            sec_cnt <= sec_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    beep     <= 1'b0;
                    ringing  <= 1'b0;
                    snoozing <= 1'b0;
                end
            endcase
        end
    end

endmodule
